// File: rtl/param_router.sv
// Parametrised N-port wormhole router: per-input FIFOs, per-output round-robin
// arbitration with packet locking, registered outputs and invalid-destination dropping.
module param_router #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned DEST_W    = $clog2(NUM_PORTS) + 1,
  parameter int unsigned FLIT_W    = 1 + DEST_W + DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [NUM_PORTS*FLIT_W-1:0] out_flit,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [15:0]                 drop_cnt
);

  localparam int unsigned PortW = $clog2(NUM_PORTS);
  localparam int unsigned AddrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  typedef logic [PortW-1:0] port_t;

  // Input FIFO storage and pointers
  logic [FLIT_W-1:0]    fifo_mem_q [NUM_PORTS][BUF_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q [NUM_PORTS];
  logic [AddrW-1:0]     wr_ptr_d [NUM_PORTS];
  logic [AddrW-1:0]     rd_ptr_q [NUM_PORTS];
  logic [AddrW-1:0]     rd_ptr_d [NUM_PORTS];
  logic [CntW-1:0]      count_q  [NUM_PORTS];
  logic [CntW-1:0]      count_d  [NUM_PORTS];
  // at_head: the flit at the FIFO head starts a packet; dropping: discarding a packet body
  logic [NUM_PORTS-1:0] at_head_q, at_head_d;
  logic [NUM_PORTS-1:0] dropping_q, dropping_d;

  // Output-side state
  logic [NUM_PORTS-1:0] lock_q, lock_d;
  port_t                lock_owner_q [NUM_PORTS];
  port_t                lock_owner_d [NUM_PORTS];
  port_t                rr_ptr_q [NUM_PORTS];
  port_t                rr_ptr_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]    out_flit_q [NUM_PORTS];
  logic [FLIT_W-1:0]    out_flit_d [NUM_PORTS];
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  // FIFO head decode
  logic [FLIT_W-1:0]    head_flit [NUM_PORTS];
  logic [DEST_W-1:0]    head_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0] fifo_empty, fifo_full, head_tail, dest_ok;
  logic [NUM_PORTS-1:0] push, pop, drop_pop;
  logic [NUM_PORTS-1:0] req [NUM_PORTS];
  logic [NUM_PORTS-1:0] load, load_head;
  port_t                load_src [NUM_PORTS];
  logic [16:0]          drop_sum;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      head_flit[i]  = fifo_mem_q[i][rd_ptr_q[i]];
      head_dest[i]  = head_flit[i][DATA_W +: DEST_W];
      head_tail[i]  = head_flit[i][FLIT_W-1];
      fifo_empty[i] = (count_q[i] == '0);
      fifo_full[i]  = (count_q[i] == CntW'(BUF_DEPTH));
      dest_ok[i]    = (head_dest[i] < DEST_W'(NUM_PORTS));
      push[i]       = in_valid[i] && !fifo_full[i];
      drop_pop[i]   = !fifo_empty[i] && ((at_head_q[i] && !dest_ok[i]) || dropping_q[i]);
    end
  end

  assign in_ready = ~fifo_full;

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = !fifo_empty[i] && at_head_q[i] && dest_ok[i] &&
                    (head_dest[i] == DEST_W'(o));
      end
    end
  end

  // Per-output arbitration: locked outputs only take their owner's body flits.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      load[o]      = 1'b0;
      load_head[o] = 1'b0;
      load_src[o]  = '0;
      if (!out_valid_q[o] || out_ready[o]) begin
        if (lock_q[o]) begin
          if (!fifo_empty[lock_owner_q[o]]) begin
            load[o]     = 1'b1;
            load_src[o] = lock_owner_q[o];
          end
        end else begin
          // Scan lowest priority first so the highest-priority requester wins.
          for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q[o]) + k;
            if (idx >= int'(NUM_PORTS)) idx = idx - int'(NUM_PORTS);
            if (req[o][idx]) begin
              load[o]      = 1'b1;
              load_head[o] = 1'b1;
              load_src[o]  = port_t'(idx);
            end
          end
        end
      end
    end
  end

  always_comb begin
    pop = drop_pop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (load[o]) pop[load_src[o]] = 1'b1;
    end
  end

  // Input-side next state
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NUM_PORTS; i++) begin
      wr_ptr_d[i]   = wr_ptr_q[i] + AddrW'(push[i]);
      rd_ptr_d[i]   = rd_ptr_q[i] + AddrW'(pop[i]);
      count_d[i]    = count_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      at_head_d[i]  = pop[i] ? head_tail[i] : at_head_q[i];
      dropping_d[i] = drop_pop[i] ? !head_tail[i] : dropping_q[i];
      if (drop_pop[i] && at_head_q[i]) drop_sum = drop_sum + 17'd1;
    end
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Output-side next state
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      lock_d[o]       = lock_q[o];
      lock_owner_d[o] = lock_owner_q[o];
      rr_ptr_d[o]     = rr_ptr_q[o];
      out_valid_d[o]  = out_valid_q[o];
      out_flit_d[o]   = out_flit_q[o];
      if (load[o]) begin
        out_valid_d[o] = 1'b1;
        out_flit_d[o]  = head_flit[load_src[o]];
        lock_d[o]      = !head_tail[load_src[o]];
        if (load_head[o]) begin
          lock_owner_d[o] = load_src[o];
          rr_ptr_d[o]     = (int'(load_src[o]) == int'(NUM_PORTS) - 1) ? '0 :
                            load_src[o] + port_t'(1);
        end
      end else if (out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '{default: '0};
      rd_ptr_q     <= '{default: '0};
      count_q      <= '{default: '0};
      at_head_q    <= '1;
      dropping_q   <= '0;
      lock_q       <= '0;
      lock_owner_q <= '{default: '0};
      rr_ptr_q     <= '{default: '0};
      out_valid_q  <= '0;
      out_flit_q   <= '{default: '0};
      drop_cnt_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      at_head_q    <= at_head_d;
      dropping_q   <= dropping_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_flit_q   <= out_flit_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage needs no reset: pointers alone define occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) fifo_mem_q[i][wr_ptr_q[i]] <= in_flit[i*FLIT_W +: FLIT_W];
    end
  end

  always_comb begin
    out_flit = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_flit[o*FLIT_W +: FLIT_W] = out_flit_q[o];
    end
  end

  assign out_valid = out_valid_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_param_router.sv
// Directed bench for param_router (4 ports, 8-bit payload, depth 4) with a
// per-output scoreboard of expected flits.
module tb_param_router;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int BD = 4;
  localparam int DESTW = 3;
  localparam int FW = 1 + DESTW + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   in_valid;
  logic [NP*FW-1:0] in_flit;
  logic [NP-1:0]   in_ready;
  logic [NP-1:0]   out_valid;
  logic [NP*FW-1:0] out_flit;
  logic [NP-1:0]   out_ready;
  logic [15:0]     drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [FW-1:0] exp_q [NP][$];

  param_router #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .BUF_DEPTH (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic t, input logic [DESTW-1:0] d,
                                       input logic [DW-1:0] p);
    return {t, d, p};
  endfunction

  function automatic logic [FW-1:0] oslice(input int o);
    return out_flit[o*FW +: FW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a flit on port p until the handshake edge.
  task automatic send1(input int p, input logic [FW-1:0] f);
    int guard;
    guard = 0;
    in_valid[p] = 1'b1;
    in_flit[p*FW +: FW] = f;
    while (!in_ready[p] && guard < 100) begin
      tick();
      guard++;
    end
    chk("send_ready_timeout", 32'(guard < 100), 32'd1);
    tick();
    in_valid[p] = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && guard < 200) begin
      tick();
      guard++;
    end
    chk("drain_timeout", 32'(guard < 200), 32'd1);
    repeat (3) tick();
  endtask

  // Scoreboard: every accepted output flit must be the next expected one.
  always @(negedge clk) begin
    if (!rst) begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          n_checks++;
          assert (exp_q[o].size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_out%0d: observed %0h expected none", o, oslice(o));
          end
          if (exp_q[o].size() != 0) chk($sformatf("sb_out%0d", o), 32'(oslice(o)),
                                        32'(exp_q[o].pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] wf [4];
    logic [FW-1:0] bp [6];

    rst = 1'b1;
    in_valid = '0;
    in_flit = '0;
    out_ready = '1;
    repeat (3) tick();
    rst = 1'b0;

    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_flit", 32'(out_flit == '0), 32'd1);
    chk("reset_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'hF);

    // Single flit, one-cycle latency
    f = mk(1'b1, 3'd2, 8'hA5);
    exp_q[2].push_back(f);
    in_valid[0] = 1'b1;
    in_flit[0*FW +: FW] = f;
    tick();
    in_valid[0] = 1'b0;
    chk("single_not_early", 32'(out_valid), 32'h0);
    tick();
    chk("single_out_valid", 32'(out_valid), 32'b0100);
    chk("single_out_flit", 32'(oslice(2)), 32'(f));
    chk("single_drop_cnt", 32'(drop_cnt), 32'h0);
    wait_drain();

    // Contention: inputs 0,1,3 to output 1 in one cycle
    in_valid = 4'b1011;
    in_flit[0*FW +: FW] = mk(1'b1, 3'd1, 8'h10);
    in_flit[1*FW +: FW] = mk(1'b1, 3'd1, 8'h11);
    in_flit[3*FW +: FW] = mk(1'b1, 3'd1, 8'h13);
    exp_q[1].push_back(mk(1'b1, 3'd1, 8'h10));
    exp_q[1].push_back(mk(1'b1, 3'd1, 8'h11));
    exp_q[1].push_back(mk(1'b1, 3'd1, 8'h13));
    tick();
    in_valid = '0;
    tick();
    chk("cont_first", 32'(oslice(1)), 32'(mk(1'b1, 3'd1, 8'h10)));
    tick();
    chk("cont_second", 32'(oslice(1)), 32'(mk(1'b1, 3'd1, 8'h11)));
    tick();
    chk("cont_third", 32'(oslice(1)), 32'(mk(1'b1, 3'd1, 8'h13)));
    chk("cont_third_valid", 32'(out_valid[1]), 32'd1);
    wait_drain();

    // rr_ptr[1] has wrapped to 0; lone input 1 is granted at once
    f = mk(1'b1, 3'd1, 8'h21);
    exp_q[1].push_back(f);
    in_valid[1] = 1'b1;
    in_flit[1*FW +: FW] = f;
    tick();
    in_valid[1] = 1'b0;
    tick();
    chk("cont_single_valid", 32'(out_valid), 32'b0010);
    chk("cont_single_flit", 32'(oslice(1)), 32'(f));
    wait_drain();

    // Wormhole: 3-flit packet from input 0 holds output 2 against input 1
    wf[0] = mk(1'b0, 3'd2, 8'h30);
    wf[1] = mk(1'b0, 3'd5, 8'h31);
    wf[2] = mk(1'b1, 3'd0, 8'h32);
    wf[3] = mk(1'b1, 3'd2, 8'h40);
    for (int i = 0; i < 4; i++) exp_q[2].push_back(wf[i]);
    in_valid[0] = 1'b1;
    in_flit[0*FW +: FW] = wf[0];
    tick();
    in_flit[0*FW +: FW] = wf[1];
    in_valid[1] = 1'b1;
    in_flit[1*FW +: FW] = wf[3];
    tick();
    chk("worm_flit0", 32'(oslice(2)), 32'(wf[0]));
    in_flit[0*FW +: FW] = wf[2];
    in_valid[1] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    chk("worm_flit1", 32'(oslice(2)), 32'(wf[1]));
    tick();
    chk("worm_flit2", 32'(oslice(2)), 32'(wf[2]));
    tick();
    chk("worm_other_head", 32'(oslice(2)), 32'(wf[3]));
    wait_drain();

    // Backpressure on output 3 while input 2 streams a 6-flit packet
    for (int i = 0; i < 6; i++) bp[i] = mk(i == 5, (i == 0) ? 3'd3 : 3'd7, 8'(8'h50 + i));
    out_ready[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q[3].push_back(bp[i]);
      send1(2, bp[i]);
    end
    chk("bp_in_ready_low", 32'(in_ready[2]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid_held", 32'(out_valid[3]), 32'd1);
      chk("bp_out_flit_stable", 32'(oslice(3)), 32'(bp[0]));
      tick();
    end
    chk("bp_in_ready_still_low", 32'(in_ready[2]), 32'd0);
    out_ready[3] = 1'b1;
    exp_q[3].push_back(bp[5]);
    send1(2, bp[5]);
    wait_drain();

    // Drop: invalid-destination packet then a good one
    send1(1, mk(1'b0, 3'd5, 8'h60));
    send1(1, mk(1'b1, 3'd1, 8'h61));
    f = mk(1'b1, 3'd0, 8'h62);
    exp_q[0].push_back(f);
    send1(1, f);
    wait_drain();
    chk("drop_cnt_one", 32'(drop_cnt), 32'd1);

    // Reset mid-packet
    send1(0, mk(1'b0, 3'd3, 8'h70));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'hF);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("midrst_out_flit", 32'(out_flit == '0), 32'd1);
    exp_q[1].push_back(mk(1'b0, 3'd1, 8'h81));
    exp_q[1].push_back(mk(1'b1, 3'd6, 8'h82));
    send1(0, mk(1'b0, 3'd1, 8'h81));
    send1(0, mk(1'b1, 3'd6, 8'h82));
    wait_drain();
    chk("final_idle", 32'(out_valid), 32'h0);
    chk("final_drop_cnt", 32'(drop_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_router.md
Name: param_router

Overview:
- Parametrised N-port wormhole router, the next generation of the fixed-port router.
- Built from per-port input FIFOs, per-output round-robin arbiters and registered output stages.
- Sits in the mesh between network interfaces and neighbouring routers.
- Generalises port count, buffer depth and payload width. Adds packet locking (wormhole), invalid-destination packet dropping and a drop counter.

Parameters:
NUM_PORTS, 4, number of input/output ports (2..8)
DATA_W, 32, flit payload width
BUF_DEPTH, 4, input FIFO depth per port (power of 2, >=2)
DEST_W, $clog2(NUM_PORTS)+1, destination field width (one spare bit so out-of-range values are representable)
FLIT_W, 1+DEST_W+DATA_W, derived; flit layout {tail[FLIT_W-1], dest[DEST_W-1:0], payload[DATA_W-1:0]}

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  NUM_PORTS  flit valid, bit i for input i
in_flit  input  NUM_PORTS*FLIT_W  flits, slice i at [i*FLIT_W +: FLIT_W]
in_ready  output  NUM_PORTS  input i FIFO not full
out_valid  output  NUM_PORTS  registered output valid
out_flit  output  NUM_PORTS*FLIT_W  registered output flits, same slicing
out_ready  input  NUM_PORTS  downstream accepts
drop_cnt  output  16  dropped-packet count, saturating

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - Clears all FIFOs, pointers, output locks, round-robin pointers (to 0), head-tracking state and drop_cnt.
  - out_valid=0, out_flit=0, drop_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-packet discards all in-flight flits; no partial packet survives.
- Input side:
  - Transfer when in_valid[i]&&in_ready[i].
  - in_ready[i]=!full[i] and is purely a function of FIFO occupancy, never of in_valid.
  - Full FIFO with simultaneous pop: in_ready stays 0 that cycle (no pass-through when full).
- Packet framing:
  - First flit after reset, or after a flit with tail=1, is a head flit. Single-flit packet: head with tail=1.
  - dest is read only from the head flit.
- Routing: head with dest<NUM_PORTS requests output dest.
- Drop: head with dest>=NUM_PORTS.
  - Drops that flit and all following flits of the packet, through the tail, one per cycle from the FIFO head.
  - drop_cnt increments once per packet, on the head, saturating at 16'hFFFF.
- Arbitration: per output o, round-robin among inputs whose FIFO head is a head flit requesting o, while o is unlocked.
  - Priority starts at rr_ptr[o].
  - On a head grant to input g, rr_ptr[o] <= (g+1) mod NUM_PORTS.
- Lock:
  - A granted output stays locked to input g until g's tail flit is loaded into the output register.
  - Other inputs' heads to o wait, with FIFO contents preserved.
  - Body flits of g go only to o.
  - A head flit of the next packet from g may be arbitrated the cycle after its tail loads.
- Output stage:
  - out register for o loads (pops the granted FIFO) when !out_valid[o] || out_ready[o].
  - Full throughput: one flit per cycle per output with out_ready held high.
  - out_flit holds stable while out_valid&&!out_ready.
- Latency: flit accepted at edge k appears with out_valid at edge k+1 at the earliest (1 cycle), given an unlocked/owned output and an empty or draining register.
- Ordering: flits from one input to one output are delivered in order; packets are never interleaved on an output.
- Different inputs targeting different outputs proceed simultaneously, with no interference.

Test Plan:
- Single flit: NUM_PORTS=4, DATA_W=8. Input 0 sends {tail=1,dest=2,payload=8'hA5} -> out_valid[2]=1 next cycle with identical flit; other outputs stay 0; drop_cnt=0.
- Contention: inputs 0,1,3 each send a 1-flit packet to output 1 in the same cycle, rr_ptr=0, out_ready=1 -> output order 0,1,3 on consecutive cycles; then rr_ptr[1]=0. Repeat with input 1 only -> granted immediately.
- Wormhole:
  - Input 0 sends a 3-flit packet to output 2 (tail only on flit 3); input 1 sends a head to output 2 one cycle later.
  - Expected output: 3 flits from input 0 contiguous, then input 1's flit.
- Backpressure:
  - out_ready[3]=0 while input 2 streams 6 flits to output 3, BUF_DEPTH=4 -> in_ready[2] drops to 0 after the output register plus 4 FIFO entries are full; out_flit stable.
  - Release out_ready -> all 6 flits delivered in order, no loss or duplication.
- Drop: input 1 sends a 2-flit packet with dest=5 (>=4), then a 1-flit packet with dest=0 -> nothing on outputs for the first packet; drop_cnt=1; second packet appears on output 0.
- Reset mid-packet: assert rst for 1 cycle after flit 1 of a 3-flit packet -> all out_valid=0, in_ready=4'hF, drop_cnt=0; a new packet afterwards is routed normally, with its first flit treated as head.
